focus_metric_accumulator: RTL and testbench

- Downstream consumer of the filter stage's per-pixel edge-magnitude stream (e.g. sobel output) and its delayed VGA sync signals.
- Accumulates thresholded edge energy inside a programmable centre region of interest (ROI) over each frame.
- Publishes a per-frame sharpness sum and count, plus a running peak. This is the metric for the auto-focus mode (KEY[3]/SW[9]).

---
 rtl/focus_pkg.sv | 23 ++
 rtl/vga_pixel_counter.sv | 49 ++++
 rtl/focus_metric_accumulator.sv | 167 ++++++++++++++++
 tb/tb_focus_metric_accumulator.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/focus_pkg.sv
// Shared types and helpers for the focus-metric pipeline: FSM state encoding,
// default accumulator widths and a saturating adder.
package focus_pkg;

    typedef enum logic {
        SYNC = 1'b0,
        RUN  = 1'b1
    } fm_state_t;

    localparam int SUM_W_DEF = 32;
    localparam int CNT_W_DEF = 20;

    // Operands are zero-extended into 64 bits; callers truncate the result back.
    function automatic logic [63:0] sat_add(input logic [63:0] a,
                                            input logic [63:0] b,
                                            input logic [63:0] max_val);
        if (a >= max_val || b > (max_val - a)) begin
            return max_val;
        end
        return a + b;
    endfunction

endpackage

// File: rtl/vga_pixel_counter.sv
// Tracks pixel column/row from registered blank/vsync and flags line ends and
// vsync falling edges; reusable by any stage fed the delayed sync signals.
module vga_pixel_counter #(
    parameter int WIDTH  = 800,
    parameter int HEIGHT = 480,
    parameter int X_W    = $clog2(WIDTH + 1),
    parameter int Y_W    = $clog2(HEIGHT + 1)
) (
    input  logic           VGA_CLK,
    input  logic           reset,
    input  logic           blank_q,
    input  logic           vs_q,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic           line_end,
    output logic           vs_fall
);

    logic blank_d;
    logic vs_d;

    assign vs_fall  = ~vs_q & vs_d;
    assign line_end = ~blank_q & blank_d;

    // x and y saturate so over-long lines or frames never wrap back into the ROI.
    always_ff @(posedge VGA_CLK) begin
        if (reset) begin
            blank_d <= 1'b0;
            vs_d    <= 1'b1;
            x       <= '0;
            y       <= '0;
        end else begin
            blank_d <= blank_q;
            vs_d    <= vs_q;
            if (vs_fall) begin
                x <= '0;
                y <= '0;
            end else if (line_end) begin
                x <= '0;
                if (y != Y_W'(HEIGHT)) begin
                    y <= y + Y_W'(1);
                end
            end else if (blank_q && (x != X_W'(WIDTH))) begin
                x <= x + X_W'(1);
            end
        end
    end

endmodule

// File: rtl/focus_metric_accumulator.sv
// Per-frame thresholded edge-energy sum/count inside a centre ROI, with a
// running peak of the frame sums; drives the auto-focus metric.
module focus_metric_accumulator
    import focus_pkg::*;
#(
    parameter int WIDTH  = 800,
    parameter int HEIGHT = 480,
    parameter int ROI_X0 = 200,
    parameter int ROI_X1 = 599,
    parameter int ROI_Y0 = 120,
    parameter int ROI_Y1 = 359,
    parameter int SUM_W  = SUM_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic             VGA_CLK,
    input  logic             reset,
    input  logic [7:0]       edge_in,
    input  logic             blank_n,
    input  logic             vs,
    input  logic [7:0]       threshold,
    input  logic             clear_peak,
    output logic [SUM_W-1:0] frame_sum,
    output logic [CNT_W-1:0] frame_count,
    output logic             frame_valid,
    output logic [SUM_W-1:0] peak_sum,
    output logic             new_peak,
    output fm_state_t        state_dbg
);

    localparam int X_W = $clog2(WIDTH + 1);
    localparam int Y_W = $clog2(HEIGHT + 1);
    localparam logic [63:0] SUM_MAX = (64'd1 << SUM_W) - 64'd1;
    localparam logic [63:0] CNT_MAX = (64'd1 << CNT_W) - 64'd1;

    logic [7:0]       edge_q;
    logic             blank_q;
    logic             vs_q;
    logic [X_W-1:0]   x;
    logic [Y_W-1:0]   y;
    logic             line_end;
    logic             vs_fall;
    fm_state_t        state_q;
    fm_state_t        state_d;
    logic [SUM_W-1:0] sum;
    logic [CNT_W-1:0] count;
    logic [SUM_W-1:0] sum_hold;
    logic [CNT_W-1:0] cnt_hold;
    logic             latch_pending;
    logic             frame_end;
    logic             in_roi;
    logic             qualify;
    logic [SUM_W-1:0] peak_base;

    always_ff @(posedge VGA_CLK) begin
        if (reset) begin
            edge_q  <= '0;
            blank_q <= 1'b0;
            vs_q    <= 1'b1;
        end else begin
            edge_q  <= edge_in;
            blank_q <= blank_n;
            vs_q    <= vs;
        end
    end

    vga_pixel_counter #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT),
        .X_W    (X_W),
        .Y_W    (Y_W)
    ) u_pix_cnt (
        .VGA_CLK  (VGA_CLK),
        .reset    (reset),
        .blank_q  (blank_q),
        .vs_q     (vs_q),
        .x        (x),
        .y        (y),
        .line_end (line_end),
        .vs_fall  (vs_fall)
    );

    always_ff @(posedge VGA_CLK) begin
        if (reset) begin
            state_q <= SYNC;
        end else begin
            state_q <= state_d;
        end
    end

    // SYNC discards the partial frame seen after reset; the first vsync edge arms RUN.
    always_comb begin
        state_d = state_q;
        if (vs_fall) begin
            state_d = RUN;
        end
    end

    assign state_dbg = state_q;
    assign frame_end = (state_q == RUN) && vs_fall;

    always_comb begin
        in_roi = (x >= X_W'(ROI_X0)) && (x <= X_W'(ROI_X1)) &&
                 (y >= Y_W'(ROI_Y0)) && (y <= Y_W'(ROI_Y1)) &&
                 (x < X_W'(WIDTH));
        // The vsync edge wins over a pixel arriving in the same cycle.
        qualify = (state_q == RUN) && blank_q && !vs_fall && in_roi &&
                  (edge_q >= threshold);
    end

    always_ff @(posedge VGA_CLK) begin
        if (reset || vs_fall) begin
            sum   <= '0;
            count <= '0;
        end else if (qualify) begin
            sum   <= SUM_W'(sat_add(64'(sum), 64'(edge_q), SUM_MAX));
            count <= CNT_W'(sat_add(64'(count), 64'd1, CNT_MAX));
        end
    end

    always_ff @(posedge VGA_CLK) begin
        if (reset) begin
            latch_pending <= 1'b0;
            sum_hold      <= '0;
            cnt_hold      <= '0;
        end else begin
            latch_pending <= frame_end;
            if (frame_end) begin
                sum_hold <= sum;
                cnt_hold <= count;
            end
        end
    end

    // A clear arriving with the latch takes effect first, so the compare is against zero.
    always_comb begin
        peak_base = peak_sum;
        if (clear_peak) begin
            peak_base = '0;
        end
    end

    // frame_valid is a single-cycle strobe; frame_sum/frame_count hold until the next one.
    always_ff @(posedge VGA_CLK) begin
        if (reset) begin
            frame_sum   <= '0;
            frame_count <= '0;
            frame_valid <= 1'b0;
            peak_sum    <= '0;
            new_peak    <= 1'b0;
        end else begin
            frame_valid <= latch_pending;
            new_peak    <= 1'b0;
            if (clear_peak) begin
                peak_sum <= '0;
            end
            if (latch_pending) begin
                frame_sum   <= sum_hold;
                frame_count <= cnt_hold;
                if (sum_hold > peak_base) begin
                    peak_sum <= sum_hold;
                    new_peak <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_focus_metric_accumulator.sv
// Bench for focus_metric_accumulator: a small-frame geometry, two instances
// (full-width and narrow saturating accumulators) checked against a frame-level model.
module tb_focus_metric_accumulator;
    import focus_pkg::*;

    localparam int W   = 8;
    localparam int H   = 4;
    localparam int RX0 = 2;
    localparam int RX1 = 5;
    localparam int RY0 = 1;
    localparam int RY1 = 2;
    localparam int SW_B = 8;
    localparam int CW_B = 3;
    localparam logic [63:0] SUM_MAX_B = 64'd255;
    localparam logic [63:0] CNT_MAX_B = 64'd7;

    logic        VGA_CLK = 1'b0;
    logic        reset;
    logic [7:0]  edge_in;
    logic        blank_n;
    logic        vs;
    logic [7:0]  threshold;
    logic        clear_peak;

    logic [31:0] fs_a;
    logic [19:0] fc_a;
    logic        fv_a;
    logic [31:0] pk_a;
    logic        np_a;
    fm_state_t   st_a;
    logic [7:0]  fs_b;
    logic [2:0]  fc_b;
    logic        fv_b;
    logic [7:0]  pk_b;
    logic        np_b;
    fm_state_t   st_b;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    bit armed  = 0;

    logic [31:0] exp_sum_q[$];
    logic [31:0] exp_cnt_q[$];
    int          exp_due_q[$];

    logic [7:0]  pix [H][W];
    logic [63:0] obs_fs_a, obs_fc_a, obs_pk_a, obs_np_a, obs_fs_b, obs_fc_b;

    always #20 VGA_CLK = ~VGA_CLK;

    focus_metric_accumulator #(
        .WIDTH(W), .HEIGHT(H), .ROI_X0(RX0), .ROI_X1(RX1),
        .ROI_Y0(RY0), .ROI_Y1(RY1), .SUM_W(32), .CNT_W(20)
    ) dut_a (
        .VGA_CLK(VGA_CLK), .reset(reset), .edge_in(edge_in), .blank_n(blank_n),
        .vs(vs), .threshold(threshold), .clear_peak(clear_peak),
        .frame_sum(fs_a), .frame_count(fc_a), .frame_valid(fv_a),
        .peak_sum(pk_a), .new_peak(np_a), .state_dbg(st_a)
    );

    focus_metric_accumulator #(
        .WIDTH(W), .HEIGHT(H), .ROI_X0(RX0), .ROI_X1(RX1),
        .ROI_Y0(RY0), .ROI_Y1(RY1), .SUM_W(SW_B), .CNT_W(CW_B)
    ) dut_b (
        .VGA_CLK(VGA_CLK), .reset(reset), .edge_in(edge_in), .blank_n(blank_n),
        .vs(vs), .threshold(threshold), .clear_peak(clear_peak),
        .frame_sum(fs_b), .frame_count(fc_b), .frame_valid(fv_b),
        .peak_sum(pk_b), .new_peak(np_b), .state_dbg(st_b)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: peak and held-output model, compared every cycle.
    initial begin
        bit          clr_s, rst_s, np;
        logic [63:0] m_fs_a, m_fc_a, m_pk_a, m_fs_b, m_fc_b, m_pk_b;
        logic [63:0] s, c, base;
        int          due;
        m_fs_a = 0; m_fc_a = 0; m_pk_a = 0;
        m_fs_b = 0; m_fc_b = 0; m_pk_b = 0;
        forever begin
            @(posedge VGA_CLK);
            cyc++;
            clr_s = clear_peak;
            rst_s = reset;
            @(negedge VGA_CLK);
            if (rst_s) begin
                m_fs_a = 0; m_fc_a = 0; m_pk_a = 0;
                m_fs_b = 0; m_fc_b = 0; m_pk_b = 0;
                exp_sum_q.delete(); exp_cnt_q.delete(); exp_due_q.delete();
                check("rst_frame_sum", fs_a, 0);
                check("rst_frame_count", fc_a, 0);
                check("rst_frame_valid", fv_a, 0);
                check("rst_peak_sum", pk_a, 0);
                check("rst_new_peak", np_a, 0);
                check("rst_b_frame_sum", fs_b, 0);
                check("rst_b_peak_sum", pk_b, 0);
            end else if (fv_a) begin
                if (exp_sum_q.size() == 0) begin
                    check("spurious_frame_valid", fv_a, 0);
                end else begin
                    s   = 64'(exp_sum_q.pop_front());
                    c   = 64'(exp_cnt_q.pop_front());
                    due = exp_due_q.pop_front();
                    check("frame_valid_latency", 64'(cyc), 64'(due));
                    base = clr_s ? 64'd0 : m_pk_a;
                    np = (s > base);
                    if (np) m_pk_a = s; else if (clr_s) m_pk_a = 0;
                    m_fs_a = s; m_fc_a = c;
                    check("frame_sum", fs_a, m_fs_a);
                    check("frame_count", fc_a, m_fc_a);
                    check("peak_sum", pk_a, m_pk_a);
                    check("new_peak", np_a, 64'(np));
                    m_fs_b = (s > SUM_MAX_B) ? SUM_MAX_B : s;
                    m_fc_b = (c > CNT_MAX_B) ? CNT_MAX_B : c;
                    base = clr_s ? 64'd0 : m_pk_b;
                    np = (m_fs_b > base);
                    if (np) m_pk_b = m_fs_b; else if (clr_s) m_pk_b = 0;
                    check("b_frame_valid", fv_b, 1);
                    check("b_frame_sum", fs_b, m_fs_b);
                    check("b_frame_count", fc_b, m_fc_b);
                    check("b_peak_sum", pk_b, m_pk_b);
                    check("b_new_peak", np_b, 64'(np));
                    obs_fs_a = 64'(fs_a); obs_fc_a = 64'(fc_a);
                    obs_pk_a = 64'(pk_a); obs_np_a = 64'(np_a);
                    obs_fs_b = 64'(fs_b); obs_fc_b = 64'(fc_b);
                end
            end else begin
                if (clr_s) begin
                    m_pk_a = 0;
                    m_pk_b = 0;
                end
                if (exp_due_q.size() != 0 && cyc > exp_due_q[0]) begin
                    check("frame_valid_timeout", fv_a, 1);
                    void'(exp_sum_q.pop_front());
                    void'(exp_cnt_q.pop_front());
                    void'(exp_due_q.pop_front());
                end
                check("hold_frame_sum", fs_a, m_fs_a);
                check("hold_frame_count", fc_a, m_fc_a);
                check("hold_peak_sum", pk_a, m_pk_a);
                check("idle_new_peak", np_a, 0);
                check("b_idle_frame_valid", fv_b, 0);
                check("b_hold_frame_sum", fs_b, m_fs_b);
                check("b_hold_peak_sum", pk_b, m_pk_b);
            end
        end
    end

    task automatic step();
        @(posedge VGA_CLK);
        #1;
    endtask

    task automatic fill_const(input int v);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                pix[y][x] = 8'(v);
    endtask

    task automatic fill_alt();
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                pix[y][x] = (x % 2 == 0) ? 8'd5 : 8'd20;
    endtask

    task automatic fill_boundary();
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                pix[y][x] = (x == 1 || x == 2 || x == 5 || x == 6) ? 8'd1 : 8'd0;
    endtask

    task automatic fill_rand();
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                pix[y][x] = 8'($urandom_range(0, 255));
    endtask

    // One frame: H active lines (plus optional over-long pixels), then vblank with
    // a vsync pulse. Expected totals come straight from the ROI/threshold rule.
    task automatic run_frame(input int thr, input bit clr_latch, input int rst_line,
                             input int extra);
        int s, c;
        s = 0;
        c = 0;
        for (int y = RY0; y <= RY1; y++)
            for (int x = RX0; x <= RX1; x++)
                if (int'(pix[y][x]) >= thr) begin
                    s += int'(pix[y][x]);
                    c++;
                end
        threshold = 8'(thr);
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W + extra; x++) begin
                blank_n = 1'b1;
                edge_in = (x < W) ? pix[y][x] : 8'($urandom_range(1, 255));
                reset   = (y == rst_line) && (x == 0);
                if (reset) armed = 0;
                step();
            end
            reset = 1'b0;
            for (int i = 0; i < 3; i++) begin
                blank_n = 1'b0;
                edge_in = 8'($urandom_range(0, 255));
                step();
            end
        end
        for (int i = 0; i < 12; i++) begin
            blank_n    = 1'b0;
            vs         = !(i >= 2 && i < 5);
            clear_peak = clr_latch && (i == 4);
            if (i == 2) begin
                if (armed) begin
                    exp_sum_q.push_back(32'(s));
                    exp_cnt_q.push_back(32'(c));
                    exp_due_q.push_back(cyc + 3);
                end
                armed = 1;
            end
            step();
        end
        clear_peak = 1'b0;
        vs = 1'b1;
    endtask

    initial begin
        reset = 1'b1; edge_in = '0; blank_n = 1'b0; vs = 1'b1;
        threshold = '0; clear_peak = 1'b0;
        obs_fs_a = '1; obs_fc_a = '1; obs_pk_a = '1; obs_np_a = '1;
        obs_fs_b = '1; obs_fc_b = '1;
        repeat (3) step();
        reset = 1'b0;
        step();
        check("state_after_reset", st_a, SYNC);

        fill_const(10); run_frame(0, 0, -1, 0);
        check("state_after_first_vsync", st_a, RUN);
        fill_const(10); run_frame(0, 0, -1, 0);
        check("basic_sum_80", obs_fs_a, 80);
        check("basic_count_8", obs_fc_a, 8);
        check("basic_peak_80", obs_pk_a, 80);
        check("basic_new_peak", obs_np_a, 1);
        check("basic_b_count_sat_7", obs_fc_b, 7);

        fill_alt(); run_frame(10, 0, -1, 0);
        check("thr10_sum_80", obs_fs_a, 80);
        check("thr10_count_4", obs_fc_a, 4);
        check("thr10_equal_no_peak", obs_np_a, 0);
        run_frame(21, 0, -1, 0);
        check("thr21_sum_0", obs_fs_a, 0);
        check("thr21_count_0", obs_fc_a, 0);

        fill_const(5); run_frame(0, 0, -1, 0);
        check("peak5_held_80", obs_pk_a, 80);
        check("peak5_new_peak_0", obs_np_a, 0);
        fill_const(12); run_frame(0, 1, -1, 0);
        check("peak12_clear_96", obs_pk_a, 96);
        check("peak12_new_peak_1", obs_np_a, 1);

        clear_peak = 1'b1; step(); clear_peak = 1'b0;
        check("clear_peak_alone", pk_a, 0);
        step();

        fill_const(255); run_frame(0, 0, -1, 0);
        check("sat_a_sum_2040", obs_fs_a, 2040);
        check("sat_b_sum_255", obs_fs_b, 255);

        fill_boundary(); run_frame(1, 0, -1, 0);
        check("roi_boundary_count_4", obs_fc_a, 4);
        check("roi_boundary_sum_4", obs_fs_a, 4);

        fill_const(10); run_frame(0, 0, 2, 0);
        check("midreset_peak_0", pk_a, 0);
        fill_const(10); run_frame(0, 0, -1, 0);
        check("midreset_next_sum_80", obs_fs_a, 80);
        check("midreset_next_peak_80", obs_pk_a, 80);

        for (int f = 0; f < 8; f++) begin
            fill_rand();
            run_frame($urandom_range(0, 120), 1'($urandom_range(0, 1)), -1,
                      $urandom_range(0, 2));
        end

        for (int i = 0; i < 20 && exp_sum_q.size() != 0; i++) step();
        check("pending_frames", 64'(exp_sum_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
